// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote command link: transmit
// sequencing states, robot response codes and counter sizing.
package remote_comm_pkg;

   // Byte-sequencing states: waiting, sending high byte, sending low byte
   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } tx_state_e;

   // Response bytes returned by the robot
   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_PROG = 8'h5A;

   // Start + 8 data + stop
   localparam int FRAME_BITS = 10;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART. The transmitter shifts a start/data/stop frame out on
// TX; the receiver synchronizes RX, samples mid-bit and holds the last good
// byte with a ready flag. The two halves share nothing but clk and rst.
module remote_comm_uart
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       TX,
   input  logic       RX,
   output logic [7:0] rx_data,
   output logic       rdy,
   input  logic       clr_rdy
);

   localparam int BAUD_W = cnt_width(BAUD_DIV);
   localparam int BIT_W  = cnt_width(FRAME_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
   localparam logic [BIT_W-1:0]  STOP_BIT  = BIT_W'(FRAME_BITS - 1);

   // ---------------- transmitter ----------------
   logic                tx_busy_q,  tx_busy_d;
   logic [BAUD_W-1:0]   tx_baud_q,  tx_baud_d;
   logic [BIT_W-1:0]    tx_bit_q,   tx_bit_d;
   logic [9:0]          tx_shift_q, tx_shift_d;
   logic                tx_bit_end;

   // Next-state for the transmit shifter; a new frame may load on the very
   // cycle the previous stop bit finishes, so back-to-back bytes have no gap.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      tx_busy_d  = tx_busy_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_bit_end = tx_busy_q && (tx_baud_q == '0);
      tx_done    = tx_bit_end && (tx_bit_q == STOP_BIT);
      if (tx_bit_end) begin
         if (tx_done) begin
            tx_busy_d  = 1'b0;
            tx_shift_d = '1;
         end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_baud_d  = BAUD_LAST;
         end
      end else if (tx_busy_q) begin
         tx_baud_d = tx_baud_q - 1'b1;
      end
      if (trmt && (!tx_busy_q || tx_done)) begin
         tx_busy_d  = 1'b1;
         tx_shift_d = {1'b1, tx_data, 1'b0};
         tx_bit_d   = '0;
         tx_baud_d  = BAUD_LAST;
      end
   end

   // Transmit registers; the shifter LSB drives TX directly, so TX is glitch-free
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it sits inside the clocked block and only acts on an edge.
      if (rst) begin
         tx_busy_q  <= 1'b0;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else begin
         // NOTE: state updates are non-blocking so every flop samples pre-edge values.
         tx_busy_q  <= tx_busy_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   assign TX = tx_shift_q[0];

   // ---------------- receiver ----------------
   logic                rx_meta_q,  rx_sync_q,  rx_prev_q;
   logic                rx_busy_q,  rx_busy_d;
   logic [BAUD_W-1:0]   rx_baud_q,  rx_baud_d;
   logic [BIT_W-1:0]    rx_bit_q,   rx_bit_d;
   logic [7:0]          rx_shift_q, rx_shift_d;
   logic [7:0]          rx_data_q,  rx_data_d;
   logic                rdy_q,      rdy_d;
   logic                start_det, rx_sample, rx_set;

   // Start detection, mid-bit sampling and the ready flag (set beats clear)
   always_comb begin
      rx_busy_d  = rx_busy_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_set     = 1'b0;
      start_det  = !rx_busy_q && rx_prev_q && !rx_sync_q;
      rx_sample  = rx_busy_q && (rx_baud_q == '0);
      if (start_det) begin
         rx_busy_d = 1'b1;
         rx_baud_d = HALF_LAST;
         rx_bit_d  = '0;
      end else if (rx_sample) begin
         rx_baud_d = BAUD_LAST;
         rx_bit_d  = rx_bit_q + 1'b1;
         if (rx_bit_q == STOP_BIT) begin
            // A low stop bit is a framing error: drop the byte silently
            rx_busy_d = 1'b0;
            rx_bit_d  = '0;
            if (rx_sync_q) begin
               rx_data_d = rx_shift_q;
               rx_set    = 1'b1;
            end
         end else if (rx_bit_q != '0) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
         end
      end else if (rx_busy_q) begin
         rx_baud_d = rx_baud_q - 1'b1;
      end
      rdy_d = rdy_q;
      if (clr_rdy || start_det) rdy_d = 1'b0;
      if (rx_set)               rdy_d = 1'b1;
   end

   // Receive registers; synchronizer and edge-history flops preset to line idle
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rdy_q      <= 1'b0;
      end else begin
         rx_meta_q  <= RX;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_busy_q  <= rx_busy_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rdy_q      <= rdy_d;
      end
   end

   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;

endmodule

// File: rtl/remote_comm.sv
// Command link to the robot: sends a 16-bit command as two UART bytes (high
// byte first) and reports the robot's one-byte responses.
module remote_comm #(
   parameter int BAUD_DIV = 5208
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd,
   input  logic        snd_cmd,
   output logic        cmd_snt,
   output logic        TX,
   input  logic        RX,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   input  logic        clr_resp_rdy
);

   import remote_comm_pkg::*;

   tx_state_e   state_q,   state_d;
   logic [7:0]  low_q,     low_d;
   logic        cmd_snt_q, cmd_snt_d;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done;

   // Byte sequencing; trmt is decoded here rather than registered so the
   // high-byte start bit appears on the cycle right after snd_cmd
   always_comb begin
      state_d   = state_q;
      low_d     = low_q;
      cmd_snt_d = cmd_snt_q;
      trmt      = 1'b0;
      tx_data   = low_q;
      case (state_q)
         IDLE: begin
            tx_data = cmd[15:8];
            if (snd_cmd) begin
               trmt      = 1'b1;
               low_d     = cmd[7:0];
               cmd_snt_d = 1'b0;
               state_d   = HIGH;
            end
         end
         HIGH: begin
            if (tx_done) begin
               trmt    = 1'b1;
               state_d = LOW;
            end
         end
         LOW: begin
            if (tx_done) begin
               cmd_snt_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, latched low byte and the sticky cmd_snt flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         low_q     <= 8'h00;
         cmd_snt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         low_q     <= low_d;
         cmd_snt_q <= cmd_snt_d;
      end
   end

   assign cmd_snt = cmd_snt_q;

   remote_comm_uart #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart (
      .clk     (clk),
      .rst     (rst),
      .trmt    (trmt),
      .tx_data (tx_data),
      .tx_done (tx_done),
      .TX      (TX),
      .RX      (RX),
      .rx_data (resp),
      .rdy     (resp_rdy),
      .clr_rdy (clr_resp_rdy)
   );

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: send, busy-ignore, receive,
// framing error, loopback and reset abort. Outputs sampled on negedge.
module tb_remote_comm;

   localparam int BAUD = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd;
   logic        snd_cmd;
   logic        cmd_snt;
   logic        tx;
   logic        dut_rx;
   logic        rx_drv;
   logic        loop_en;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        clr_resp_rdy;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int accept_cyc = 0;
   int snt_rises = 0;
   logic snt_prev = 1'b0;

   assign dut_rx = loop_en ? tx : rx_drv;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      snt_prev <= cmd_snt;
      if (cmd_snt === 1'b1 && snt_prev === 1'b0) snt_rises <= snt_rises + 1;
   end

   remote_comm #(.BAUD_DIV(BAUD)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cmd),
      .snd_cmd      (snd_cmd),
      .cmd_snt      (cmd_snt),
      .TX           (tx),
      .RX           (dut_rx),
      .resp         (resp),
      .resp_rdy     (resp_rdy),
      .clr_resp_rdy (clr_resp_rdy)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Pulse snd_cmd for one cycle; caller is at a negedge
   task automatic start_cmd(input logic [15:0] c);
      cmd     = c;
      snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd    = 1'b0;
      accept_cyc = cyc;
   endtask

   // Wait (bounded) for a TX start bit, then sample 10 bits of BAUD cycles each
   task automatic capture_frame(output logic [7:0] data, output bit ok, output int waits);
      logic [9:0] bits;
      ok    = 1'b1;
      waits = 0;
      data  = 8'h00;
      bits  = '1;
      while (tx !== 1'b0 && waits < 400) begin
         @(negedge clk);
         waits++;
      end
      if (tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int b = 0; b < 10; b++) begin
         bits[b] = tx;
         for (int s = 0; s < BAUD; s++) begin
            if (tx !== bits[b]) ok = 1'b0;
            @(negedge clk);
         end
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      data = bits[8:1];
   endtask

   // Drive one RX frame from the bench, with a chosen stop-bit level
   task automatic rx_send(input logic [7:0] data, input logic stop);
      logic [9:0] bits;
      bits = {stop, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx_drv = bits[b];
         repeat (BAUD) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic wait_snt(input string name);
      int n;
      n = 0;
      while (cmd_snt !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_snt !== 1'b1 || (cyc - accept_cyc) > 20 * BAUD + 4) begin
         failures++;
         $display("FAIL %s cmd_snt: got %b after %0d cycles, need 1 within %0d", name, cmd_snt,
                  cyc - accept_cyc, 20 * BAUD + 4);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd = 16'h0000; snd_cmd = 1'b0; clr_resp_rdy = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || cmd_snt !== 1'b0 || resp !== 8'h00 || resp_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset: tx=%b cmd_snt=%b resp=%h resp_rdy=%b, need 1 0 00 0",
                  tx, cmd_snt, resp, resp_rdy);
      end
      rst = 1'b0;
   endtask

   task automatic test_send();
      logic [7:0] d; bit ok; int w;
      @(negedge clk);
      start_cmd(16'h29A5);
      checks++;
      if (tx !== 1'b0) begin
         failures++;
         $display("FAIL send_start_latency: tx=%b, need 0 on cycle after snd_cmd", tx);
      end
      capture_frame(d, ok, w);
      checks++;
      if (!ok || d !== 8'h29 || w != 0) begin
         failures++;
         $display("FAIL send_high: byte=%h ok=%b wait=%0d, need 29 1 0", d, ok, w);
      end
      capture_frame(d, ok, w);
      checks++;
      if (!ok || d !== 8'hA5 || w > 2) begin
         failures++;
         $display("FAIL send_low: byte=%h ok=%b gap=%0d, need A5 1 <=2", d, ok, w);
      end
      wait_snt("send");
   endtask

   task automatic test_busy_ignore();
      logic [7:0] d1, d2; bit ok1, ok2; int w1, w2; int rises0; bit stayed_high;
      @(negedge clk);
      rises0 = snt_rises;
      start_cmd(16'h29A5);
      checks++;
      if (cmd_snt !== 1'b0) begin
         failures++;
         $display("FAIL busy_snt_clear: cmd_snt=%b, need 0 after new snd_cmd", cmd_snt);
      end
      fork
         begin
            capture_frame(d1, ok1, w1);
            capture_frame(d2, ok2, w2);
         end
         begin
            repeat (40) @(negedge clk);
            cmd     = 16'h1234;
            snd_cmd = 1'b1;
            @(negedge clk);
            snd_cmd = 1'b0;
         end
      join
      checks++;
      if (!ok1 || !ok2 || d1 !== 8'h29 || d2 !== 8'hA5) begin
         failures++;
         $display("FAIL busy_bytes: got %h %h (ok %b %b), need 29 A5", d1, d2, ok1, ok2);
      end
      wait_snt("busy");
      stayed_high = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1) stayed_high = 1'b0;
      end
      checks++;
      if (!stayed_high || (snt_rises - rises0) != 1) begin
         failures++;
         $display("FAIL busy_single_cmd: tx_idle=%b snt_rises=%0d, need 1 1",
                  stayed_high, snt_rises - rises0);
      end
   endtask

   task automatic test_receive();
      @(negedge clk);
      rx_send(8'hA5, 1'b1);
      @(negedge clk);
      checks++;
      if (resp_rdy !== 1'b1 || resp !== 8'hA5) begin
         failures++;
         $display("FAIL rx_good: resp=%h rdy=%b, need A5 1", resp, resp_rdy);
      end
      clr_resp_rdy = 1'b1;
      @(negedge clk);
      clr_resp_rdy = 1'b0;
      checks++;
      if (resp_rdy !== 1'b0 || resp !== 8'hA5) begin
         failures++;
         $display("FAIL rx_clear: resp=%h rdy=%b, need A5 0", resp, resp_rdy);
      end
   endtask

   task automatic test_framing();
      rx_send(8'h5A, 1'b0);
      repeat (40) @(negedge clk);
      checks++;
      if (resp_rdy !== 1'b0 || resp !== 8'hA5) begin
         failures++;
         $display("FAIL rx_framing: resp=%h rdy=%b, need A5 0", resp, resp_rdy);
      end
      rx_send(8'h5A, 1'b1);
      @(negedge clk);
      checks++;
      if (resp_rdy !== 1'b1 || resp !== 8'h5A) begin
         failures++;
         $display("FAIL rx_after_framing: resp=%h rdy=%b, need 5A 1", resp, resp_rdy);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] d1, d2; bit ok1, ok2; int w1, w2;
      loop_en = 1'b1;
      @(negedge clk);
      start_cmd(16'hA55A);
      fork
         begin
            capture_frame(d1, ok1, w1);
            capture_frame(d2, ok2, w2);
         end
         begin
            logic [7:0] exp_b [2];
            exp_b[0] = 8'hA5;
            exp_b[1] = 8'h5A;
            for (int k = 0; k < 2; k++) begin
               int n;
               n = 0;
               while (resp_rdy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
               n = 0;
               while (resp_rdy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
               checks++;
               if (resp_rdy !== 1'b1 || resp !== exp_b[k]) begin
                  failures++;
                  $display("FAIL loop_rx%0d: resp=%h rdy=%b, need %h 1", k, resp, resp_rdy, exp_b[k]);
               end
            end
         end
      join
      checks++;
      if (!ok1 || !ok2 || d1 !== 8'hA5 || d2 !== 8'h5A || w2 > 2) begin
         failures++;
         $display("FAIL loop_tx: got %h %h (ok %b %b gap %0d), need A5 5A", d1, d2, ok1, ok2, w2);
      end
      wait_snt("loop");
      loop_en = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [7:0] d; bit ok; int w;
      @(negedge clk);
      start_cmd(16'h29A5);
      // Land in data bit 4 of 0x29, which is a 0 on the line
      repeat (5 * BAUD + 7) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         failures++;
         $display("FAIL abort_pre: tx=%b, need 0 mid bit 4 of 0x29", tx);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || cmd_snt !== 1'b0 || resp_rdy !== 1'b0 || resp !== 8'h00) begin
         failures++;
         $display("FAIL abort_reset: tx=%b cmd_snt=%b rdy=%b resp=%h, need 1 0 0 00",
                  tx, cmd_snt, resp_rdy, resp);
      end
      repeat (3) @(negedge clk);
      // First cycle out of reset already accepts snd_cmd
      rst = 1'b0;
      start_cmd(16'hC33C);
      checks++;
      if (tx !== 1'b0 || cmd_snt !== 1'b0) begin
         failures++;
         $display("FAIL abort_restart: tx=%b cmd_snt=%b, need 0 0", tx, cmd_snt);
      end
      capture_frame(d, ok, w);
      checks++;
      if (!ok || d !== 8'hC3 || w != 0) begin
         failures++;
         $display("FAIL abort_high: byte=%h ok=%b wait=%0d, need C3 1 0", d, ok, w);
      end
      capture_frame(d, ok, w);
      checks++;
      if (!ok || d !== 8'h3C || w > 2) begin
         failures++;
         $display("FAIL abort_low: byte=%h ok=%b gap=%0d, need 3C 1 <=2", d, ok, w);
      end
      wait_snt("abort");
   endtask

   initial begin
      test_reset();
      test_send();
      test_busy_ignore();
      test_receive();
      test_framing();
      test_loopback();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
